sram22_port_ctrl: RTL and testbench

- Initiator-side controller for one sram22 single-port macro (e.g. 1024x32, byte-masked write, 1-cycle registered read).
- Converts a valid/ready request channel from the core into macro pin activity (ce/we/wmask/addr/din).
- Returns read data on a valid/ready response channel through a credit-limited response FIFO, so backpressure never loses SRAM output.
- Sits between the tile datapath and the macro; exactly one controller per macro.

---
 rtl/sram22_port_ctrl_pkg.sv | 19 +
 rtl/sram22_rsp_fifo.sv | 59 +++++
 rtl/sram22_port_ctrl.sv | 134 +++++++++++++
 tb/tb_sram22_port_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_port_ctrl_pkg.sv
// Shared types and default sizing for the sram22 port controller and its response FIFO.
package sram22_port_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_WMASK_WIDTH = 4;
    localparam int DEF_RSP_DEPTH   = 2;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Small synchronous FIFO holding read responses; synchronous reset flushes all entries.
module sram22_rsp_fifo
    import sram22_port_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH,
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [cnt_width(DEPTH)-1:0] cnt,
    output logic [WIDTH-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push && (cnt < DEPTH_C);
    assign do_pop  = pop && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sram22_port_ctrl.sv
// Request/response front end for one sram22 single-port macro with credit-limited read returns.
// Optional power-up zero fill of the macro is enabled by defining SRAM22_PORT_CTRL_CLEAR_EN.
module sram22_port_ctrl
    import sram22_port_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
    parameter int RSP_DEPTH   = DEF_RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int CW = cnt_width(RSP_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

    state_t                  state;
    logic                    rd_pend;
    logic [CW-1:0]           rsp_cnt;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [CW:0]             credit_sum;
    logic                    credit_ok;
    logic                    accept;
    logic                    pop;
    logic                    clear_active;
    logic [ADDR_WIDTH-1:0]   clear_addr;

`ifdef SRAM22_PORT_CTRL_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_addr;

    // Zero-fill sweep: one full-mask write per cycle, then hand the port to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
            if (clr_addr == '1) begin
                state <= RUN;
            end
        end
    end

    assign clear_active = ~rst & (state == CLEAR);
    assign clear_addr   = clr_addr;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end
    end

    assign clear_active = 1'b0;
    assign clear_addr   = '0;
`endif

    // Reads reserve a FIFO slot at issue, counting both buffered data and the read still inside the macro.
    assign credit_sum = (CW+1)'(rsp_cnt) + (CW+1)'(rd_pend);
    assign credit_ok  = credit_sum < DEPTH_C;

    always_comb begin
        req_ready = 1'b0;
        if (!rst && state == RUN) begin
            req_ready = req_we | credit_ok;
        end
    end

    assign accept    = req_valid & req_ready;
    assign sram_rstb = ~rst;

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (clear_active) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = clear_addr;
        end else if (accept) begin
            sram_ce    = 1'b1;
            sram_we    = req_we;
            sram_wmask = req_we ? req_wmask : '0;
            sram_addr  = req_addr;
            sram_din   = req_wdata;
        end
    end

    // Macro output is valid the cycle after a read is issued; capture it then.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= accept & ~req_we;
        end
    end

    assign rsp_valid = ~rst & (rsp_cnt != '0);
    assign rsp_rdata = rsp_valid ? fifo_head : '0;
    assign pop       = rsp_valid & rsp_ready;

    sram22_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (sram_dout),
        .pop       (pop),
        .cnt       (rsp_cnt),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Directed scoreboard bench for sram22_port_ctrl with a behavioural sram22 macro model.
// Covers the SRAM22_PORT_CTRL_CLEAR_EN build when that macro is defined.
module tb_sram22_port_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [MW-1:0] req_wmask = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          sram_rstb;
    logic          sram_ce;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_lat = 0;
    int rsp_seen = 0;
    logic [DW-1:0] last_rdata = '0;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_q [$];
    int            stamp_q [$];

    sram22_port_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_rstb  (sram_rstb),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural macro: byte-masked write, registered read.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (sram_wmask[b]) mem_model[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= mem_model[sram_addr];
            end
        end
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
`ifdef SRAM22_PORT_CTRL_CLEAR_EN
        return '0;
`else
        return 'x;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: expected read data is queued at the handshake, compared when popped.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        logic [DW-1:0] cur;
        int            s;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
`ifdef SRAM22_PORT_CTRL_CLEAR_EN
            ref_mem.delete();
`endif
        end else begin
            checkOutput("cnt_bound", 32'(32'(dut.rsp_cnt) <= DEPTH), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL unexpected_rsp: observed=%h expected=none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    checkOutput("rsp_data", rsp_rdata, e);
                    last_lat = cyc - s;
                    checkOutput("rsp_latency_min", 32'(last_lat >= 2), 32'd1);
                    last_rdata = rsp_rdata;
                    rsp_seen++;
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    cur = ref_read(req_addr);
                    for (int b = 0; b < MW; b++) begin
                        if (req_wmask[b]) cur[8*b +: 8] = req_wdata[8*b +: 8];
                    end
                    ref_mem[int'(req_addr)] = cur;
                end else begin
                    exp_q.push_back(ref_read(req_addr));
                    stamp_q.push_back(cyc);
                end
            end
        end
    end

    // Offer one request and hold it until accepted, bounded.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [MW-1:0] wmask);
        int  waited = 0;
        bit  done = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL handshake_timeout: observed=no_ready expected=ready addr=%h", addr);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : stimulus
        logic [AW-1:0] stall_addr [4];
        int idx;
        int n;
        int seen0;
        stall_addr[0] = 10'd5;
        stall_addr[1] = 10'd7;
        stall_addr[2] = 10'd20;
        stall_addr[3] = 10'd5;

        // Reset with a busy request offered: every macro pin and handshake must stay quiet.
        rst = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = '1;
        req_wdata = '1;
        req_wmask = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_sram_rstb", sram_rstb, 0);
        checkOutput("rst_sram_ce", sram_ce, 0);
        checkOutput("rst_sram_we", sram_we, 0);
        checkOutput("rst_sram_wmask", sram_wmask, 0);
        checkOutput("rst_sram_addr", sram_addr, 0);
        checkOutput("rst_sram_din", sram_din, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;

`ifdef SRAM22_PORT_CTRL_CLEAR_EN
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready || n > 1100) break;
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("clear_cycles", 32'(n), 32'd1024);
        applyStimulus(1'b0, 10'd0, '0, '0);
        waitDrain("clear_drain_0");
        checkOutput("clear_rd_0", last_rdata, 32'h0);
        applyStimulus(1'b0, 10'd511, '0, '0);
        waitDrain("clear_drain_511");
        checkOutput("clear_rd_511", last_rdata, 32'h0);
        applyStimulus(1'b0, 10'd1023, '0, '0);
        waitDrain("clear_drain_1023");
        checkOutput("clear_rd_1023", last_rdata, 32'h0);
`else
        @(negedge clk);
        checkOutput("post_rst_req_ready", req_ready, 1);
        checkOutput("post_rst_rsp_valid", rsp_valid, 0);
        checkOutput("post_rst_sram_rstb", sram_rstb, 1);
        @(posedge clk);
        #1;
`endif

        // Full write then read back with minimum latency.
        applyStimulus(1'b1, 10'd5, 32'hDEADBEEF, 4'b1111);
        applyStimulus(1'b0, 10'd5, '0, '0);
        waitDrain("t1_drain");
        checkOutput("t1_rdata", last_rdata, 32'hDEADBEEF);
        checkOutput("t1_latency", 32'(last_lat), 32'd2);

        // Byte-masked overwrite merges with the old word.
        applyStimulus(1'b1, 10'd7, 32'h11223344, 4'b1111);
        applyStimulus(1'b1, 10'd7, 32'hAABBCCDD, 4'b0101);
        applyStimulus(1'b0, 10'd7, '0, '0);
        waitDrain("t2_drain");
        checkOutput("t2_rdata", last_rdata, 32'h11BB33DD);

        // Consumer stalled: reads stop at the credit limit, writes still flow.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        idx = 0;
        req_addr = stall_addr[0];
        repeat (6) begin
            @(negedge clk);
            if (req_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 4) req_addr = stall_addr[idx];
        end
        checkOutput("stall_accepts", 32'(idx), 32'd2);
        @(negedge clk);
        checkOutput("stall_rd_ready", req_ready, 0);
        checkOutput("stall_cnt", 32'(dut.rsp_cnt), 32'd2);
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = 10'd20;
        req_wdata = 32'h55AA55AA;
        req_wmask = 4'b1111;
        @(negedge clk);
        checkOutput("stall_wr_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_we    = 1'b0;
        req_wdata = '0;
        req_wmask = '0;
        req_addr  = stall_addr[idx];
        rsp_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 50) begin
            @(negedge clk);
            if (req_ready) idx++;
            @(posedge clk);
            #1;
            n++;
            if (idx < 4) req_addr = stall_addr[idx];
        end
        req_valid = 1'b0;
        checkOutput("stall_resume", 32'(idx), 32'd4);
        waitDrain("t3_drain");
        checkOutput("t3_last_rdata", last_rdata, 32'hDEADBEEF);

        // Streaming reads over a filled block; responses must come back in address order.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, AW'(i), 32'hC0DE0000 + 32'(i), 4'b1111);
        end
        seen0 = rsp_seen;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, AW'(i), '0, '0);
        end
        waitDrain("t4_drain");
        checkOutput("t4_rsp_count", 32'(rsp_seen - seen0), 32'd16);
        checkOutput("t4_last_rdata", last_rdata, 32'hC0DE000F);

        // Reset one cycle after a read handshake: the read is lost and nothing emerges later.
        applyStimulus(1'b0, 10'd3, '0, '0);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd9;
        @(negedge clk);
        checkOutput("t5_rst_sram_ce", sram_ce, 0);
        checkOutput("t5_rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t5_rst_cnt", 32'(dut.rsp_cnt), 32'd0);
        checkOutput("t5_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t5_post_rsp_valid", rsp_valid, 0);
            checkOutput("t5_post_cnt", 32'(dut.rsp_cnt), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
